// File: rtl/ram_bank_if.sv
// Port bundle for ram_bank: read/write port A, read-only port B and the init status.
// The master drives requests and observes data; the slave is the memory bank.
interface ram_bank_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                  init_busy;

  logic                  a_ena;
  logic                  a_wena;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [BE_WIDTH-1:0]   a_be;
  logic [DATA_WIDTH-1:0] a_din;
  logic [DATA_WIDTH-1:0] a_dout;
  logic                  a_valid;

  logic                  b_ena;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_dout;
  logic                  b_valid;

  modport master (
    input  init_busy,
    output a_ena, a_wena, a_addr, a_be, a_din,
    input  a_dout, a_valid,
    output b_ena, b_addr,
    input  b_dout, b_valid
  );

  modport slave (
    output init_busy,
    input  a_ena, a_wena, a_addr, a_be, a_din,
    output a_dout, a_valid,
    input  b_ena, b_addr,
    output b_dout, b_valid
  );
endinterface

// File: rtl/ram_bank.sv
// Data memory bank: byte-writable port A, read-only port B, self-clearing after reset,
// read latency of 1 or 2 cycles with one-cycle valid strobes.
module ram_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RDW_MODE   = 0
) (
  input  logic       clk,
  input  logic       rst,
  ram_bank_if.slave  bus
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [ADDR_WIDTH-1:0] clr_addr_next;
  logic                  clr_we;
  logic                  ready;
  logic                  busy_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  a_wr;
  logic                  a_rd;
  logic                  b_rd;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic [DATA_WIDTH-1:0] b_rdata;

  logic [DATA_WIDTH-1:0] a_stage;
  logic                  a_stage_v;
  logic [DATA_WIDTH-1:0] b_stage;
  logic                  b_stage_v;

  logic [DATA_WIDTH-1:0] a_dout_q;
  logic                  a_valid_q;
  logic [DATA_WIDTH-1:0] b_dout_q;
  logic                  b_valid_q;

  // Sequencer state and clear counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      busy_q   <= 1'b1;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
      busy_q   <= (state_next == ST_CLEAR);
    end
  end

  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    clr_we        = 1'b0;
    ready         = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we        = 1'b1;
        clr_addr_next = clr_addr + ADDR_WIDTH'(1);
        if (clr_addr == LAST_ADDR) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        ready = 1'b1;
      end
      default: begin
        state_next = ST_CLEAR;
      end
    endcase
  end

  // Requests count only in READY and never in a cycle where rst is sampled
  assign a_wr = ready & ~rst & bus.a_ena &  bus.a_wena;
  assign a_rd = ready & ~rst & bus.a_ena & ~bus.a_wena;
  assign b_rd = ready & ~rst & bus.b_ena;

  // Storage: clear has priority, otherwise byte-masked port A write
  always_ff @(posedge clk) begin
    if (clr_we && !rst) begin
      mem[clr_addr] <= '0;
    end else if (a_wr) begin
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
        if (bus.a_be[i]) begin
          mem[bus.a_addr][8*i +: 8] <= bus.a_din[8*i +: 8];
        end
      end
    end
  end

  assign a_rdata = mem[bus.a_addr];

  // Write-first collision forwards only the enabled bytes of the concurrent A write
  always_comb begin
    b_rdata = mem[bus.b_addr];
    if ((RDW_MODE == 1) && a_wr && (bus.a_addr == bus.b_addr)) begin
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
        if (bus.a_be[i]) begin
          b_rdata[8*i +: 8] = bus.a_din[8*i +: 8];
        end
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] a_s1;
    logic                  a_s1_v;
    logic [DATA_WIDTH-1:0] b_s1;
    logic                  b_s1_v;

    // Extra pipeline register between array and output
    always_ff @(posedge clk) begin
      if (rst) begin
        a_s1   <= '0;
        a_s1_v <= 1'b0;
        b_s1   <= '0;
        b_s1_v <= 1'b0;
      end else begin
        a_s1_v <= a_rd;
        b_s1_v <= b_rd;
        if (a_rd) a_s1 <= a_rdata;
        if (b_rd) b_s1 <= b_rdata;
      end
    end

    assign a_stage   = a_s1;
    assign a_stage_v = a_s1_v;
    assign b_stage   = b_s1;
    assign b_stage_v = b_s1_v;
  end else begin : g_lat1
    assign a_stage   = a_rdata;
    assign a_stage_v = a_rd;
    assign b_stage   = b_rdata;
    assign b_stage_v = b_rd;
  end

  // Output registers; data holds when no read completes
  always_ff @(posedge clk) begin
    if (rst) begin
      a_dout_q  <= '0;
      a_valid_q <= 1'b0;
      b_dout_q  <= '0;
      b_valid_q <= 1'b0;
    end else begin
      a_valid_q <= a_stage_v;
      b_valid_q <= b_stage_v;
      if (a_stage_v) a_dout_q <= a_stage;
      if (b_stage_v) b_dout_q <= b_stage;
    end
  end

  assign bus.init_busy = busy_q;
  assign bus.a_dout    = a_dout_q;
  assign bus.a_valid   = a_valid_q;
  assign bus.b_dout    = b_dout_q;
  assign bus.b_valid   = b_valid_q;

endmodule

// File: tb/tb_ram_bank.sv
// Directed bench for ram_bank: two instances (latency 1 / read-first and
// latency 2 / write-first) share one stimulus stream and are checked against hand values.
module tb_ram_bank;
  logic        clk;
  logic        rst;
  logic        a_ena;
  logic        a_wena;
  logic [4:0]  a_addr;
  logic [3:0]  a_be;
  logic [31:0] a_din;
  logic        b_ena;
  logic [4:0]  b_addr;

  int n_checks = 0;
  int n_errors = 0;

  ram_bank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if0 ();
  ram_bank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if1 ();

  assign if0.a_ena  = a_ena;
  assign if0.a_wena = a_wena;
  assign if0.a_addr = a_addr;
  assign if0.a_be   = a_be;
  assign if0.a_din  = a_din;
  assign if0.b_ena  = b_ena;
  assign if0.b_addr = b_addr;
  assign if1.a_ena  = a_ena;
  assign if1.a_wena = a_wena;
  assign if1.a_addr = a_addr;
  assign if1.a_be   = a_be;
  assign if1.a_din  = a_din;
  assign if1.b_ena  = b_ena;
  assign if1.b_addr = b_addr;

  ram_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .RD_LATENCY(1), .RDW_MODE(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  ram_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .RD_LATENCY(2), .RDW_MODE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be);
    a_ena = 1'b1; a_wena = 1'b1; a_addr = addr; a_din = data; a_be = be;
    tick();
    a_ena = 1'b0; a_wena = 1'b0;
  endtask

  // Port A read: instance 0 answers after one edge, instance 1 after two
  task automatic rd_a(input logic [4:0] addr, input logic [31:0] exp, input string tag);
    a_ena = 1'b1; a_wena = 1'b0; a_addr = addr;
    tick();
    a_ena = 1'b0;
    check($sformatf("%s_v0", tag), 32'(if0.a_valid), 32'd1);
    check($sformatf("%s_d0", tag), if0.a_dout, exp);
    tick();
    check($sformatf("%s_v1", tag), 32'(if1.a_valid), 32'd1);
    check($sformatf("%s_d1", tag), if1.a_dout, exp);
  endtask

  // Requests are held active during the clear; none may be answered
  task automatic wait_clear(input string tag);
    int   n;
    logic vseen;
    n = 0;
    vseen = 1'b0;
    a_ena = 1'b1; a_wena = 1'b0; a_addr = 5'd1; b_ena = 1'b1; b_addr = 5'd2;
    while (n < 100) begin
      tick();
      n++;
      vseen = vseen | if0.a_valid | if0.b_valid | if1.a_valid | if1.b_valid;
      if (!if0.init_busy) break;
    end
    a_ena = 1'b0; b_ena = 1'b0;
    check($sformatf("%s_len", tag), 32'(n), 32'd32);
    check($sformatf("%s_busy1", tag), 32'(if1.init_busy), 32'd0);
    check($sformatf("%s_novalid", tag), 32'(vseen), 32'd0);
  endtask

  // Back-to-back B reads of every address, expecting addr*mult
  task automatic b_sweep(input int mult, input string tag);
    for (int i = 0; i <= 32; i++) begin
      b_ena = (i < 32);
      b_addr = 5'(i);
      tick();
      if (i < 32) begin
        check($sformatf("%s_v0_%0d", tag, i), 32'(if0.b_valid), 32'd1);
        check($sformatf("%s_d0_%0d", tag, i), if0.b_dout, 32'(i * mult));
      end else begin
        check($sformatf("%s_v0_end", tag), 32'(if0.b_valid), 32'd0);
      end
      if (i == 0) begin
        check($sformatf("%s_v1_first", tag), 32'(if1.b_valid), 32'd0);
      end else begin
        check($sformatf("%s_v1_%0d", tag, i - 1), 32'(if1.b_valid), 32'd1);
        check($sformatf("%s_d1_%0d", tag, i - 1), if1.b_dout, 32'((i - 1) * mult));
      end
    end
    b_ena = 1'b0;
  endtask

  initial begin
    rst = 1'b1; a_ena = 1'b0; a_wena = 1'b0; a_addr = '0; a_be = '0; a_din = '0;
    b_ena = 1'b0; b_addr = '0;
    tick();
    tick();
    check("rst_busy0", 32'(if0.init_busy), 32'd1);
    check("rst_busy1", 32'(if1.init_busy), 32'd1);
    check("rst_adout0", if0.a_dout, 32'd0);
    check("rst_bdout1", if1.b_dout, 32'd0);
    check("rst_avalid0", 32'(if0.a_valid), 32'd0);
    check("rst_bvalid1", 32'(if1.b_valid), 32'd0);
    rst = 1'b0;
    wait_clear("clr0");

    // Preload addr*3 and stream it back on port B
    for (int i = 0; i < 32; i++) wr(5'(i), 32'(i * 3), 4'hF);
    b_sweep(3, "sweep3");

    // Byte enables
    wr(5'd3, 32'hAABBCCDD, 4'b1111);
    wr(5'd3, 32'h11223344, 4'b0101);
    rd_a(5'd3, 32'hAA22CC44, "be");

    // Collisions on addr 7
    wr(5'd7, 32'h0, 4'hF);
    a_ena = 1'b1; a_wena = 1'b1; a_addr = 5'd7; a_din = 32'hFFFFFFFF; a_be = 4'hF;
    b_ena = 1'b1; b_addr = 5'd7;
    tick();
    a_din = 32'h0; a_be = 4'b0011;
    check("col_v0", 32'(if0.b_valid), 32'd1);
    check("col_d0", if0.b_dout, 32'h0);
    tick();
    a_ena = 1'b0; a_wena = 1'b0; b_ena = 1'b0;
    check("col_d1", if1.b_dout, 32'hFFFFFFFF);
    check("colp_d0", if0.b_dout, 32'hFFFFFFFF);
    tick();
    check("colp_v1", 32'(if1.b_valid), 32'd1);
    check("colp_d1", if1.b_dout, 32'hFFFF0000);
    rd_a(5'd7, 32'hFFFF0000, "col_after");

    // Disabled port holds its data
    wr(5'd9, 32'h12345678, 4'hF);
    rd_a(5'd9, 32'h12345678, "hold_rd");
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("hold_d0_%0d", k), if0.a_dout, 32'h12345678);
      check($sformatf("hold_d1_%0d", k), if1.a_dout, 32'h12345678);
      check($sformatf("hold_v0_%0d", k), 32'(if0.a_valid), 32'd0);
      check($sformatf("hold_v1_%0d", k), 32'(if1.a_valid), 32'd0);
    end

    // Reset with a read in flight
    b_ena = 1'b1; b_addr = 5'd9;
    tick();
    b_ena = 1'b0;
    check("flight_d0", if0.b_dout, 32'h12345678);
    rst = 1'b1;
    tick();
    check("flight_rst_v0", 32'(if0.b_valid), 32'd0);
    check("flight_rst_d0", if0.b_dout, 32'd0);
    check("flight_rst_v1", 32'(if1.b_valid), 32'd0);
    check("flight_rst_d1", if1.b_dout, 32'd0);
    check("flight_rst_ad1", if1.a_dout, 32'd0);
    check("flight_rst_busy", 32'(if0.init_busy), 32'd1);
    rst = 1'b0;

    // Reset again at clear cycle 10
    repeat (10) tick();
    check("midclr_busy", 32'(if0.init_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_clear("clr1");

    b_sweep(0, "sweep0");
    rd_a(5'd9, 32'd0, "zero9");
    rd_a(5'd3, 32'd0, "zero3");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
